// File: rtl/sorter_seq_ctrl.sv
// sorter_seq_ctrl: sequences one top-5 sort job through the external sorter.
// Fetches ceil(cfg_len/32) 256-bit lines, streams them to the sorter, waits
// for the final qualified result and hands it out on a valid/ready port.
// Optional feature macro: SORTER_SEQ_PERF_EN (job busy-cycle counter).
module sorter_seq_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 16,
  parameter int DRAIN_TMO = 64
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [255:0]      rd_data,
  output logic              sorter_clr,
  output logic              sorter_en,
  output logic [255:0]      sorter_in,
  output logic              last_sort,
  output logic [4:0]        last_line_sorter_num,
  input  logic [255:0]      sorter_result,
  input  logic              sorter_valid,
  input  logic              last_sort_o,
  output logic [255:0]      res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       perf_cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_FEED = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam int TMO_W = $clog2(DRAIN_TMO + 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  nlines_q;
  logic [LEN_W-1:0]  line_cnt;
  logic [4:0]        lsn_q;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              done_q;
  logic [LEN_W-1:0]  nlines_d;
  logic              last_line;
  logic              feed_ack;
  logic              final_hit;

  // ceil(len/32) without widening: whole lines plus one for any remainder
  assign nlines_d  = (cfg_len >> 5) + LEN_W'(|cfg_len[4:0]);
  assign last_line = (line_cnt == nlines_q - LEN_W'(1));
  assign feed_ack  = (state == S_FEED) && rd_ack;
  assign final_hit = (state == S_WAIT) && sorter_valid && last_sort_o;

  assign busy       = (state != S_IDLE);
  assign err        = (state == S_ERR);
  assign done       = done_q | err;
  assign sorter_clr = (state == S_CLR) || (state == S_ERR);
  assign rd_req     = (state == S_FEED);
  // address wraps naturally at 2^ADDR_W; forced to 0 when no request is open
  assign rd_addr    = rd_req ? (base_q + ADDR_W'(line_cnt)) : '0;
  assign last_line_sorter_num = lsn_q;

  // Job sequencing FSM with line counter and WAIT-state drain timeout
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      nlines_q <= '0;
      lsn_q    <= '0;
      line_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base_q   <= cfg_base;
          nlines_q <= nlines_d;
          lsn_q    <= cfg_len[4:0];
          state    <= (cfg_len != '0) ? S_CLR : S_ERR;
        end
        S_CLR: begin
          line_cnt <= '0;
          state    <= S_FEED;
        end
        S_FEED: if (rd_ack) begin
          line_cnt <= line_cnt + LEN_W'(1);
          if (last_line) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sorter_valid && last_sort_o)
            state <= S_OUT;
          else if (tmo_cnt == TMO_W'(DRAIN_TMO - 1))
            state <= S_ERR;
          else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
        // res_valid is always set while in OUT, so ready alone completes it
        S_OUT:   if (res_ready) state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered hand-off of each acked line into the sorter
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sorter_en <= 1'b0;
      last_sort <= 1'b0;
      sorter_in <= '0;
    end else begin
      sorter_en <= feed_ack;
      last_sort <= feed_ack && last_line;
      if (feed_ack) sorter_in <= rd_data;
    end
  end

  // Result capture, hold until consumed, and success done pulse
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == S_OUT) && res_ready;
      if (final_hit) begin
        res_valid <= 1'b1;
        res_data  <= sorter_result;
      end else if ((state == S_OUT) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef SORTER_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: restarts on an accepted start, saturates at all-ones
  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      perf_q <= '0;
    else if ((state == S_IDLE) && start)
      perf_q <= '0;
    else if (busy && (perf_q != 32'hFFFF_FFFF))
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_sorter_seq_ctrl.sv
// Directed bench for sorter_seq_ctrl with a line-buffer model and a
// behavioural 3-cycle top-5 sorter model.
module tb_sorter_seq_ctrl;
  logic         clk = 1'b0;
  logic         rst, start, rd_req, rd_ack, busy, done, err;
  logic [15:0]  cfg_base, cfg_len, rd_addr;
  logic [255:0] rd_data, sorter_in, sorter_result, res_data;
  logic         sorter_clr, sorter_en, last_sort, sorter_valid, last_sort_o;
  logic [4:0]   lsn;
  logic         res_valid, res_ready;
  logic [31:0]  perf_cycles;

  int vecs = 0;
  int miscomp = 0;

  always #5 clk = ~clk;

  sorter_seq_ctrl #(.ADDR_W(16), .LEN_W(16), .DRAIN_TMO(64)) dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .cfg_base(cfg_base),
    .cfg_len(cfg_len), .busy(busy), .done(done), .err(err), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .sorter_clr(sorter_clr), .sorter_en(sorter_en), .sorter_in(sorter_in),
    .last_sort(last_sort), .last_line_sorter_num(lsn),
    .sorter_result(sorter_result), .sorter_valid(sorter_valid),
    .last_sort_o(last_sort_o), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready), .perf_cycles(perf_cycles));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscomp++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // line buffer: 8 lines, indexed by low address bits
  logic [255:0] mem [0:7];
  assign rd_data = mem[rd_addr[2:0]];

  // ack generator: either tied high, or a pulse after 'stall' waiting cycles
  logic ack_always, ack_q;
  int   stall, wcnt;
  assign rd_ack = ack_always | ack_q;
  always @(negedge clk) begin
    if (ack_q) begin ack_q <= 1'b0; wcnt <= 0; end
    else if (rd_req) begin
      if (wcnt >= stall) ack_q <= 1'b1; else wcnt <= wcnt + 1;
    end else wcnt <= 0;
  end

  // sorter model: top-5 by data, strict greater-than, 3-cycle output latency
  logic         mute;
  logic [119:0] acc;
  int           lineno;
  logic [2:0]   vp, lp;

  function automatic logic [119:0] merge(input logic [119:0] a, input logic [255:0] line,
                                         input int n, input int base);
    logic [119:0] r;
    logic [23:0]  e, t;
    r = a;
    for (int k = 0; k < n; k++) begin
      e = {16'(base + k), line[8*k +: 8]};
      for (int j = 0; j < 5; j++)
        if (e[7:0] > r[24*j +: 8]) begin t = r[24*j +: 24]; r[24*j +: 24] = e; e = t; end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (sorter_clr) begin acc <= '0; lineno <= 0; end
    else if (sorter_en) begin
      acc    <= merge(acc, sorter_in, (last_sort && lsn != 5'd0) ? int'(lsn) : 32, lineno * 32);
      lineno <= lineno + 1;
    end
    vp <= {vp[1:0], sorter_en & ~mute};
    lp <= {lp[1:0], sorter_en & last_sort & ~mute};
  end
  assign sorter_valid  = vp[2];
  assign last_sort_o   = lp[2];
  assign sorter_result = last_sort_o ? {136'h0, acc} : {256{1'b1}};

  // activity monitor
  logic        mon_clr;
  int          en_cnt, last_cnt, req_cnt, done_cnt, err_cnt, busy_cnt, hold_err, both_err, ack_n;
  logic [4:0]  lsn_last;
  logic [15:0] ack_addr [0:7];
  logic        p_req, p_ack;
  logic [15:0] p_addr;
  always @(posedge clk) begin
    p_req <= rd_req; p_ack <= rd_ack; p_addr <= rd_addr;
    if (mon_clr) begin
      en_cnt <= 0; last_cnt <= 0; req_cnt <= 0; done_cnt <= 0; err_cnt <= 0;
      busy_cnt <= 0; hold_err <= 0; both_err <= 0; ack_n <= 0; lsn_last <= '1;
    end else begin
      en_cnt   <= en_cnt + int'(sorter_en);
      req_cnt  <= req_cnt + int'(rd_req);
      done_cnt <= done_cnt + int'(done);
      err_cnt  <= err_cnt + int'(err);
      busy_cnt <= busy_cnt + int'(busy);
      both_err <= both_err + int'(sorter_en & sorter_clr);
      if (sorter_en && last_sort) begin last_cnt <= last_cnt + 1; lsn_last <= lsn; end
      if (rd_req && rd_ack) begin ack_addr[ack_n[2:0]] <= rd_addr; ack_n <= ack_n + 1; end
      if (p_req && !p_ack && (!rd_req || rd_addr != p_addr)) hold_err <= hold_err + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1; step(1); mon_clr = 1'b0;
  endtask

  task automatic kick(input logic [15:0] b, input logic [15:0] l);
    cfg_base = b; cfg_len = l; start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    int n = 0;
    while (res_valid !== 1'b1 && n < 400) begin step(1); n++; end
    chk(tag, res_valid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin step(1); n++; end
    chk(tag, done, 1'b1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; res_ready = 1'b0;
    ack_always = 1'b0; ack_q = 1'b0; stall = 0; wcnt = 0; mute = 1'b0;
    mon_clr = 1'b1; vp = '0; lp = '0; acc = '0; lineno = 0;
    clr_mem();
    step(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rd_req", rd_req, 1'b0);
    chk("rst_sorter_en", sorter_en, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_perf", perf_cycles, 32'd0);
    rst = 1'b0; mon_clr = 1'b0;

    // 64 elements, ack always high: two lines, last has count 0 (= full)
    clr_mem(); mem[0][8*5 +: 8] = 8'h50; mem[1][8*2 +: 8] = 8'h60;
    ack_always = 1'b1; mon_reset();
    kick(16'd0, 16'd64);
    chk("t1_clr_pulse", sorter_clr, 1'b1);
    chk("t1_busy", busy, 1'b1);
    step(1);
    chk("t1_clr_one_cycle", sorter_clr, 1'b0);
    chk("t1_rd_req", rd_req, 1'b1);
    chk("t1_rd_addr", rd_addr, 16'd0);
    wait_rv("t1_res_valid");
    chk("t1_en_cnt", en_cnt, 2);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_lsn_at_last", lsn_last, 5'd0);
    chk("t1_res_data", res_data, {136'h0, 24'h0, 24'h0, 24'h0, 24'h000550, 24'h002260});
    chk("t1_no_done_before_ready", done, 1'b0);
    res_ready = 1'b1; step(1);
    chk("t1_done", done, 1'b1);
    chk("t1_res_valid_drop", res_valid, 1'b0);
    chk("t1_idle", busy, 1'b0);
    step(1);
    chk("t1_done_pulse", done, 1'b0);

    // 70 elements: three lines, last holds 6; element 74 is outside the job
    clr_mem();
    mem[4][8*3 +: 8] = 8'h7F; mem[5][8*0 +: 8] = 8'h01;
    mem[6][8*1 +: 8] = 8'h7E; mem[6][8*10 +: 8] = 8'hFF;
    mon_reset();
    kick(16'd4, 16'd70);
    wait_done("t2_done");
    chk("t2_err", err, 1'b0);
    chk("t2_en_cnt", en_cnt, 3);
    chk("t2_lsn", lsn_last, 5'd6);
    chk("t2_addr2", ack_addr[2], 16'd6);
    chk("t2_res_data", res_data, {136'h0, 24'h0, 24'h0, 24'h002001, 24'h00417E, 24'h00037F});
    chk("t2_no_clr_en_overlap", both_err, 0);

    // zero length: immediate error, no reads, no sorter feed
    mon_reset();
    kick(16'd0, 16'd0);
    chk("t3_done", done, 1'b1);
    chk("t3_err", err, 1'b1);
    chk("t3_clr", sorter_clr, 1'b1);
    step(2);
    chk("t3_no_rd_req", req_cnt, 0);
    chk("t3_no_en", en_cnt, 0);
    chk("t3_idle", busy, 1'b0);

    // stalled acks, address wrap from 0xFFFF, ignored start mid-job
    clr_mem(); ack_always = 1'b0; stall = 5; mon_reset();
    kick(16'hFFFF, 16'd96);
    step(8);
    cfg_len = 16'd0; start = 1'b1; step(1); start = 1'b0; cfg_len = 16'd96;
    wait_done("t4_done");
    chk("t4_err", err, 1'b0);
    step(5);
    chk("t4_single_done", done_cnt, 1);
    chk("t4_no_err", err_cnt, 0);
    chk("t4_en_cnt", en_cnt, 3);
    chk("t4_addr0", ack_addr[0], 16'hFFFF);
    chk("t4_addr1", ack_addr[1], 16'h0000);
    chk("t4_addr2", ack_addr[2], 16'h0001);
    chk("t4_addr_hold", hold_err, 0);

    // sorter silent: timeout after 64 WAIT cycles
    ack_always = 1'b1; mute = 1'b1; mon_reset();
    kick(16'd0, 16'd32);
    begin
      int n = 0;
      while (!(sorter_en && last_sort) && n < 100) begin step(1); n++; end
    end
    chk("t5_last_feed", sorter_en & last_sort, 1'b1);
    step(63);
    chk("t5_no_err_early", err, 1'b0);
    chk("t5_still_busy", busy, 1'b1);
    step(1);
    chk("t5_err", err, 1'b1);
    chk("t5_done", done, 1'b1);
    chk("t5_clr", sorter_clr, 1'b1);
    step(1);
    chk("t5_idle", busy, 1'b0);
    mute = 1'b0;

    // reset in the middle of FEED
    ack_always = 1'b0; stall = 5; mon_reset();
    kick(16'd0, 16'd64);
    step(3);
    chk("t6_in_feed", rd_req, 1'b1);
    rst = 1'b1; step(1);
    chk("t6_rd_req", rd_req, 1'b0);
    chk("t6_rd_addr", rd_addr, 16'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_clr", sorter_clr, 1'b0);
    chk("t6_en", sorter_en, 1'b0);
    chk("t6_lsn", lsn, 5'd0);
    chk("t6_perf", perf_cycles, 32'd0);
    rst = 1'b0; step(30);
    chk("t6_no_done", done_cnt, 0);

    // consumer stalls 10 cycles: result held stable; perf check
    clr_mem();
    mem[2][8*0 +: 8] = 8'h22; mem[3][8*7 +: 8] = 8'h33; mem[3][8*9 +: 8] = 8'h44;
    ack_always = 1'b1; res_ready = 1'b0; mon_reset();
    kick(16'd2, 16'd40);
    wait_rv("t7_res_valid");
    for (int i = 0; i < 10; i++) begin
      chk("t7_hold_valid", res_valid, 1'b1);
      chk("t7_hold_data", res_data, {136'h0, 24'h0, 24'h0, 24'h0, 24'h000022, 24'h002733});
      step(1);
    end
    res_ready = 1'b1; step(1);
    chk("t7_done", done, 1'b1);
    chk("t7_res_valid_drop", res_valid, 1'b0);
`ifdef SORTER_SEQ_PERF_EN
    chk("t7_perf", perf_cycles, 32'(busy_cnt));
`else
    chk("t7_perf_tied", perf_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
    $finish;
  end
endmodule
